// File: rtl/rv64g_wb_arbiter.sv
// Round-robin writeback arbiter: many execution units share one regfile write-and-unlock port.
// Define RV64G_WB_ARB_OUT_REG_EN to register the write outputs (1-cycle latency); otherwise they are combinational.
module rv64g_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 5,
    parameter int DW      = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               stall_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][AW-1:0]         req_addr_i,
    input  logic [NUM_REQ-1:0][DW-1:0]         req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               wr_unlock_en_o,
    output logic [AW-1:0]                      wr_unlock_addr_o,
    output logic [DW-1:0]                      wr_unlock_data_o,
    output logic [$clog2(NUM_REQ)-1:0]         grant_idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Scan from lowest to highest priority so the highest-priority valid requester wins last.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid_i[idx] && !stall_i && !rst_i) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = grant_vld && (grant_idx == IW'(gi));
    end

    // AND-OR mux keyed by the one-hot ready vector; yields zero when nothing is granted.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i]) begin
                sel_addr = sel_addr | req_addr_i[i];
                sel_data = sel_data | req_data_i[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef RV64G_WB_ARB_OUT_REG_EN
    logic          wr_en_q,   wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [IW-1:0] wr_idx_q,  wr_idx_d;

    always_comb begin
        wr_en_d   = grant_vld;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
        wr_idx_d  = grant_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_idx_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    // Masking with rst_i kills a write registered just before reset rose, in that same cycle.
    assign wr_unlock_en_o   = wr_en_q && !rst_i;
    assign wr_unlock_addr_o = rst_i ? '0 : wr_addr_q;
    assign wr_unlock_data_o = rst_i ? '0 : wr_data_q;
    assign grant_idx_o      = rst_i ? '0 : wr_idx_q;
`else
    assign wr_unlock_en_o   = grant_vld;
    assign wr_unlock_addr_o = sel_addr;
    assign wr_unlock_data_o = sel_data;
    assign grant_idx_o      = grant_idx;
`endif

endmodule

// File: tb/tb_rv64g_wb_arbiter.sv
// Directed and model-checked bench for rv64g_wb_arbiter (NUM_REQ=4, AW=5, DW=64).
module tb_rv64g_wb_arbiter;

`ifdef RV64G_WB_ARB_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [3:0]       valid;
    logic [3:0][4:0]  addr;
    logic [3:0][63:0] data;
    logic [3:0]       ready;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [63:0]      wr_data;
    logic [1:0]       gidx;

    int total = 0;
    int bad   = 0;

    logic        pend_en   = 1'b0;
    logic [4:0]  pend_addr = '0;
    logic [63:0] pend_data = '0;
    logic [1:0]  pend_idx  = '0;

    always #5 clk = ~clk;

    rv64g_wb_arbiter #(.NUM_REQ(4), .AW(5), .DW(64)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .req_valid_i      (valid),
        .req_addr_i       (addr),
        .req_data_i       (data),
        .req_ready_o      (ready),
        .wr_unlock_en_o   (wr_en),
        .wr_unlock_addr_o (wr_addr),
        .wr_unlock_data_o (wr_data),
        .grant_idx_o      (gidx)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // g = index that must be granted this cycle, -1 for none
    task automatic step(input int g);
        logic [3:0]  er;
        logic        ee;
        logic [4:0]  ea;
        logic [63:0] ed;
        logic [1:0]  ei;
        er = '0; ee = 1'b0; ea = '0; ed = '0; ei = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ee    = 1'b1;
            ea    = addr[g];
            ed    = data[g];
            ei    = 2'(g);
        end
        @(negedge clk);
        $display("t=%0t g=%0d ready=%b en=%b addr=%0d data=%h idx=%0d",
                 $time, g, ready, wr_en, wr_addr, wr_data, gidx);
        check_val("ready", 64'(ready), 64'(er));
        if (LAT == 1) begin
            if (rst) begin
                pend_en = 1'b0; pend_addr = '0; pend_data = '0; pend_idx = '0;
            end
            check_val("wr_en",   64'(wr_en),   64'(pend_en));
            check_val("wr_addr", 64'(wr_addr), 64'(pend_addr));
            check_val("wr_data", wr_data,      pend_data);
            check_val("gidx",    64'(gidx),    64'(pend_idx));
            pend_en = ee; pend_addr = ea; pend_data = ed; pend_idx = ei;
        end else begin
            check_val("wr_en",   64'(wr_en),   64'(ee));
            check_val("wr_addr", 64'(wr_addr), 64'(ea));
            check_val("wr_data", wr_data,      ed);
            check_val("gidx",    64'(gidx),    64'(ei));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mptr;
        int g;
        int idx;
        rst   = 1'b1;
        stall = 1'b0;
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            addr[i] = 5'(8 + i);
            data[i] = 64'h1000 + 64'(i);
        end
        @(posedge clk); #1;
        step(-1);
        step(-1);

        // all valid: plain rotation with wrap
        rst = 1'b0;
        step(0); step(1); step(2); step(3); step(0); step(1);

        // ptr=2, only 0 and 3 valid
        valid = 4'b1001;
        step(3); step(0); step(3);

        // stalled request held for 3 cycles
        valid = 4'b0010; addr[1] = 5'd7; data[1] = 64'hDEAD_BEEF; stall = 1'b1;
        step(-1); step(-1); step(-1);
        stall = 1'b0;
        step(1);

        // x0 write forwarded unchanged
        valid = 4'b0100; addr[2] = 5'd0; data[2] = 64'h55;
        step(2);

        // ptr=3 wraps to 0; then stall blocks a pending request without losing it
        valid = 4'b0011;
        step(0);
        valid = 4'b0010; stall = 1'b1;
        step(-1);
        stall = 1'b0;
        step(1);

        valid = 4'b0000;
        step(-1);

        // reset right after a handshake discards it and restores ptr to 0
        valid = 4'b0001;
        step(0);
        rst = 1'b1; valid = 4'b1111;
        step(-1); step(-1);
        rst = 1'b0;
        step(0); step(1);

        // random valid/stall against a round-robin reference model
        mptr  = 2;
        valid = 4'b0000;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!valid[i] && ($urandom_range(0, 1) == 1)) begin
                    valid[i] = 1'b1;
                    addr[i]  = 5'($urandom);
                    data[i]  = {$urandom(), $urandom()};
                end
            end
            stall = ($urandom_range(0, 3) == 0);
            g = -1;
            if (!stall) begin
                for (int k = 3; k >= 0; k--) begin
                    idx = (mptr + k) % 4;
                    if (valid[idx]) g = idx;
                end
            end
            step(g);
            if (g >= 0) begin
                valid[g] = 1'b0;
                mptr     = (g + 1) % 4;
            end
        end
        valid = 4'b0000; stall = 1'b0;
        step(-1);
        step(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv64g_wb_arbiter.md
RV64G_WB_ARBITER -- requirements
Module: rv64g_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of writeback requesters (execution units); legal range 2..16, need not be a power of 2.
REQ-002 Parameter AW, default 5, SHALL set the register address width (32 integer registers).
REQ-003 Parameter DW, default 64, SHALL set the writeback data width (XLEN).
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 stall_i  input  1  SHALL, when high, block all grants (regfile write port unavailable).
REQ-007 req_valid_i  input  [NUM_REQ]  SHALL be the per-requester writeback valid.
REQ-008 req_addr_i  input  [NUM_REQ][AW]  SHALL be the per-requester destination register address.
REQ-009 req_data_i  input  [NUM_REQ][DW]  SHALL be the per-requester writeback data.
REQ-010 req_ready_o  output  [NUM_REQ]  SHALL be the per-requester accept; handshake = valid & ready in the same cycle.
REQ-011 wr_unlock_en_o  output  1  SHALL drive the regfile write-and-unlock enable.
REQ-012 wr_unlock_addr_o  output  [AW]  SHALL drive the regfile write-and-unlock address.
REQ-013 wr_unlock_data_o  output  [DW]  SHALL drive the regfile write-and-unlock data.
REQ-014 grant_idx_o  output  [$clog2(NUM_REQ)]  SHALL give the index of the requester whose write is presented on wr_unlock_*_o (0 when wr_unlock_en_o is low).

Function
REQ-015 At most one req_ready_o bit SHALL be high in any cycle (one-hot or zero).
REQ-016 Arbitration SHALL be round-robin from a pointer ptr: highest priority at ptr, then ptr+1, ..., wrapping NUM_REQ-1 -> 0.
REQ-017 req_ready_o[i] SHALL be high iff req_valid_i[i], !stall_i, !rst_i and i is the highest-priority valid requester.
REQ-018 After a grant to index g, ptr SHALL become (g+1) mod NUM_REQ on the next clock; with no grant ptr SHALL hold.
REQ-019 A continuously valid requester SHALL be granted within NUM_REQ cycles in which stall_i is low.
REQ-020 req_ready_o SHALL depend combinationally on req_valid_i; requesters SHALL NOT make req_valid_i depend on req_ready_o, and once valid SHALL hold valid, addr and data stable until the handshake.
REQ-021 A grant with req_addr_i = 0 SHALL be accepted and forwarded unchanged (the regfile discards x0 writes).
REQ-022 Without a grant wr_unlock_en_o SHALL be 0 and wr_unlock_addr_o/wr_unlock_data_o SHALL be 0.
REQ-023 Granted writes to the same address in successive cycles SHALL reach the regfile in grant order.
REQ-024 stall_i rising during a pending request SHALL drop req_ready_o the same cycle; the request stays pending without loss.

Reset
REQ-025 While rst_i is high: ptr = 0, req_ready_o = 0, wr_unlock_en_o = 0, wr_unlock_addr_o = 0, wr_unlock_data_o = 0, grant_idx_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard any registered (not yet presented) write; no write SHALL emerge in the first cycle after rst_i falls.

Configuration
REQ-027 Macro RV64G_WB_ARB_OUT_REG_EN defined: wr_unlock_*_o and grant_idx_o SHALL be registered, presenting a write exactly 1 cycle after its handshake.
REQ-028 RV64G_WB_ARB_OUT_REG_EN undefined: wr_unlock_*_o and grant_idx_o SHALL be combinational, presenting the write in the handshake cycle (0-cycle latency); arbitration and ptr behaviour identical in both builds.

Verification
REQ-029 Reset, then all 4 valid continuously, stall_i=0 -> grants 0,1,2,3,0,... one per cycle; ptr wraps 3->0.
REQ-030 ptr=2, valid on 0 and 3 only -> grant 3, then ptr=0 -> grant 0; never two ready bits high.
REQ-031 Requester 1 valid (addr 7, data 0xDEAD_BEEF) with stall_i=1 for 3 cycles then 0 -> no ready during stall, then wr_unlock_en_o=1, addr=7, data=0xDEAD_BEEF (same cycle without macro, next cycle with macro).
REQ-032 Requester 2 valid with addr 0, data 0x55 -> accepted and forwarded with wr_unlock_addr_o=0.
REQ-033 OUT_REG build: handshake on requester 0 at cycle N, rst_i high at N+1 -> wr_unlock_en_o=0 at N+1 and N+2, ptr=0 after reset.
REQ-034 Random valid/stall for 10k cycles, NUM_REQ=3 -> every write delivered exactly once, in grant order, no requester waits more than 3 unstalled cycles.
